// File: rtl/wall_mask_builder_pkg.sv
// Shared definitions for the wall mask producer and the wall tile renderer.
// The low nibble of a mask is the renderer's {left, top, right, bottom} tile select.
package wall_mask_builder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_C,
        S_L,
        S_T,
        S_R,
        S_B,
        S_W
    } state_e;

    localparam int MASK_W    = 5;
    localparam int MASK_WALL = 4;
    localparam int MASK_L    = 3;
    localparam int MASK_T    = 2;
    localparam int MASK_R    = 1;
    localparam int MASK_B    = 0;

    localparam logic [3:0] TILE_EMPTY = 4'b0000;
    localparam logic [3:0] TILE_FULL  = 4'b1111;

    // Empty cells carry no neighbour information, so the whole mask collapses to zero.
    function automatic logic [MASK_W-1:0] pack_mask(input logic wall, input logic l,
                                                   input logic t, input logic r,
                                                   input logic b);
        logic [MASK_W-1:0] m;
        m = {1'b0, TILE_EMPTY};
        if (wall) begin
            m[MASK_WALL] = 1'b1;
            m[MASK_L]    = l;
            m[MASK_T]    = t;
            m[MASK_R]    = r;
            m[MASK_B]    = b;
        end
        return m;
    endfunction

endpackage

// File: rtl/wall_mask_builder_if.sv
// Control handshake plus maze map read port and mask RAM write port.
interface wall_mask_builder_if #(
    parameter int ADDR_W = 8
);
    import wall_mask_builder_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              map_rd_en;
    logic [ADDR_W-1:0] map_rd_addr;
    logic              map_rd_data;
    logic              mask_wr_en;
    logic [ADDR_W-1:0] mask_wr_addr;
    logic [MASK_W-1:0] mask_wr_data;

    modport master (
        input  start,
        input  map_rd_data,
        output busy,
        output done,
        output map_rd_en,
        output map_rd_addr,
        output mask_wr_en,
        output mask_wr_addr,
        output mask_wr_data
    );

    modport slave (
        output start,
        output map_rd_data,
        input  busy,
        input  done,
        input  map_rd_en,
        input  map_rd_addr,
        input  mask_wr_en,
        input  mask_wr_addr,
        input  mask_wr_data
    );
endinterface

// File: rtl/wall_mask_builder_cell_scan_counter.sv
// Row-major cell position for the scan, with last-cell and neighbour in-bounds flags.
module cell_scan_counter #(
    parameter int MAZE_W = 16,
    parameter int MAZE_H = 16,
    parameter int X_W    = 4,
    parameter int Y_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           adv_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o,
    output logic           has_l_o,
    output logic           has_t_o,
    output logic           has_r_o,
    output logic           has_b_o
);
    localparam logic [X_W-1:0] X_MAX = X_W'(MAZE_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(MAZE_H - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign last_o  = (x_q == X_MAX) && (y_q == Y_MAX);
    assign has_l_o = (x_q != '0);
    assign has_t_o = (y_q != '0);
    assign has_r_o = (x_q != X_MAX);
    assign has_b_o = (y_q != Y_MAX);
endmodule

// File: rtl/wall_mask_builder.sv
// Scans the maze map once per start and writes a {wall,L,T,R,B} mask per cell.
// state | meaning
// IDLE  | waiting for start
// S_C   | read centre cell
// S_L   | capture centre, read left
// S_T   | capture left, read top
// S_R   | capture top, read right
// S_B   | capture right, read bottom
// S_W   | write mask (bottom taken straight from the map read data), advance
module wall_mask_builder
    import wall_mask_builder_pkg::*;
#(
    parameter int MAZE_W = 16,
    parameter int MAZE_H = 16,
    parameter int X_W    = 4,
    parameter int Y_W    = 4,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    wall_mask_builder_if.master bus
);
    state_e state_q, state_d;
    logic center_q, center_d;
    logic left_q, left_d;
    logic top_q, top_d;
    logic right_q, right_d;

    logic [X_W-1:0] x, rd_x;
    logic [Y_W-1:0] y, rd_y;
    logic clr, adv, last, has_l, has_t, has_r, has_b;
    logic rd_en, wr_en, done_s;

    cell_scan_counter #(
        .MAZE_W(MAZE_W),
        .MAZE_H(MAZE_H),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .adv_i  (adv),
        .x_o    (x),
        .y_o    (y),
        .last_o (last),
        .has_l_o(has_l),
        .has_t_o(has_t),
        .has_r_o(has_r),
        .has_b_o(has_b)
    );

    always_comb begin
        state_d  = state_q;
        center_d = center_q;
        left_d   = left_q;
        top_d    = top_q;
        right_d  = right_q;
        clr      = 1'b0;
        adv      = 1'b0;
        rd_en    = 1'b0;
        rd_x     = x;
        rd_y     = y;
        wr_en    = 1'b0;
        done_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    state_d = S_C;
                end
            end
            S_C: begin
                rd_en   = 1'b1;
                state_d = S_L;
            end
            S_L: begin
                center_d = bus.map_rd_data;
                rd_en    = has_l;
                rd_x     = x - X_W'(1);
                state_d  = bus.map_rd_data ? S_T : S_W;
            end
            S_T: begin
                left_d  = has_l & bus.map_rd_data;
                rd_en   = has_t;
                rd_y    = y - Y_W'(1);
                state_d = S_R;
            end
            S_R: begin
                top_d   = has_t & bus.map_rd_data;
                rd_en   = has_r;
                rd_x    = x + X_W'(1);
                state_d = S_B;
            end
            S_B: begin
                right_d = has_r & bus.map_rd_data;
                rd_en   = has_b;
                rd_y    = y + Y_W'(1);
                state_d = S_W;
            end
            S_W: begin
                wr_en = 1'b1;
                adv   = 1'b1;
                if (last) begin
                    done_s  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = S_C;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            center_q <= 1'b0;
            left_q   <= 1'b0;
            top_q    <= 1'b0;
            right_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            center_q <= center_d;
            left_q   <= left_d;
            top_q    <= top_d;
            right_q  <= right_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_s;
    assign bus.map_rd_en    = rd_en;
    assign bus.map_rd_addr  = ADDR_W'(rd_y) * ADDR_W'(MAZE_W) + ADDR_W'(rd_x);
    assign bus.mask_wr_en   = wr_en;
    assign bus.mask_wr_addr = ADDR_W'(y) * ADDR_W'(MAZE_W) + ADDR_W'(x);
    // Bottom comes from the map RAM's registered read port, so no capture cycle is needed.
    assign bus.mask_wr_data = wr_en ? pack_mask(center_q, left_q, top_q, right_q,
                                                has_b & bus.map_rd_data)
                                    : '0;
endmodule

// File: tb/tb_wall_mask_builder.sv
// Self-checking bench: fixed maps with hand-derived masks, random maps against a reference model.
module tb_wall_mask_builder;
    localparam int W = 16;
    localparam int H = 16;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wall_mask_builder_if #(.ADDR_W(8)) bus ();

    wall_mask_builder #(
        .MAZE_W(W), .MAZE_H(H), .X_W(4), .Y_W(4), .ADDR_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic       map [N];
    logic [4:0] mask_ram [N];
    int         wr_addr_q[$];
    logic [4:0] wr_data_q[$];
    int         rd_q[$];
    int         busy_cycles;
    int         done_cnt;
    int         done_on_wr;
    bit         collect = 0;
    logic       pend_en = 1'b0;
    logic [7:0] pend_addr = '0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Map RAM: registered read, garbage on cycles following no read.
    always @(negedge clk) begin
        pend_en   = bus.map_rd_en;
        pend_addr = bus.map_rd_addr;
    end
    always @(posedge clk) begin
        #1;
        bus.map_rd_data = pend_en ? map[pend_addr] : 1'($urandom);
    end

    always @(negedge clk) begin
        if (collect) begin
            if (bus.busy) busy_cycles++;
            if (bus.map_rd_en) rd_q.push_back(int'(bus.map_rd_addr));
            if (bus.mask_wr_en) begin
                wr_addr_q.push_back(int'(bus.mask_wr_addr));
                wr_data_q.push_back(bus.mask_wr_data);
                mask_ram[bus.mask_wr_addr] = bus.mask_wr_data;
                if (bus.done) done_on_wr++;
            end
            if (bus.done) done_cnt++;
        end
    end

    function automatic logic [4:0] model_mask(input int a);
        int x, y;
        logic l, t, r, b;
        x = a % W;
        y = a / W;
        l = 1'b0; t = 1'b0; r = 1'b0; b = 1'b0;
        if (!map[a]) return 5'b00000;
        if (x > 0)     l = map[a - 1];
        if (y > 0)     t = map[a - W];
        if (x < W - 1) r = map[a + 1];
        if (y < H - 1) b = map[a + W];
        return {1'b1, l, t, r, b};
    endfunction

    task automatic load_map(input int kind);
        for (int i = 0; i < N; i++) map[i] = (kind == 3) ? 1'b1 : 1'b0;
        if (kind == 1) map[85] = 1'b1;
        if (kind == 2) begin
            map[85] = 1'b1; map[84] = 1'b1; map[86] = 1'b1; map[69] = 1'b1; map[101] = 1'b1;
        end
        if (kind == 4) for (int i = 0; i < N; i++) map[i] = ($urandom_range(0, 99) < 60);
    endtask

    task automatic clear_capture();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_q.delete();
        busy_cycles = 0;
        done_cnt    = 0;
        done_on_wr  = 0;
        for (int i = 0; i < N; i++) mask_ram[i] = 5'b01010;
    endtask

    task automatic run_scan(input int restart_at);
        int n, bad, exp_cycles;
        int exp_rd[$];
        clear_capture();
        collect = 1;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check("start_latency", {29'd0, bus.busy, bus.map_rd_en, bus.map_rd_addr == 8'd0}, 7);
        n = 1;
        while (bus.busy && n < 5000) begin
            @(negedge clk);
            n++;
            bus.start = (n == restart_at);
        end
        bus.start = 1'b0;
        collect = 0;
        check("scan_timeout", int'(n >= 5000), 0);

        exp_cycles = 0;
        for (int i = 0; i < N; i++) begin
            int x, y;
            x = i % W;
            y = i / W;
            exp_cycles += map[i] ? 6 : 3;
            exp_rd.push_back(i);
            if (x > 0) exp_rd.push_back(i - 1);
            if (map[i]) begin
                if (y > 0)     exp_rd.push_back(i - W);
                if (x < W - 1) exp_rd.push_back(i + 1);
                if (y < H - 1) exp_rd.push_back(i + W);
            end
        end

        check("write_count", wr_addr_q.size(), N);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < N; i++) begin
            if (wr_addr_q[i] != i || wr_data_q[i] !== model_mask(i)) begin
                if (bad == 0)
                    $display("FAIL write_seq: write %0d addr %0d data %b, expected addr %0d data %b",
                             i, wr_addr_q[i], wr_data_q[i], i, model_mask(i));
                bad++;
            end
        end
        check("write_seq_bad", bad, 0);

        check("read_count", rd_q.size(), exp_rd.size());
        bad = 0;
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) begin
            if (rd_q[i] != exp_rd[i]) begin
                if (bad == 0)
                    $display("FAIL read_seq: read %0d addr %0d expected %0d", i, rd_q[i], exp_rd[i]);
                bad++;
            end
        end
        check("read_seq_bad", bad, 0);
        check("busy_cycles_model", busy_cycles, exp_cycles);
        check("done_count", done_cnt, 1);
        check("done_on_last_write", done_on_wr, 1);
    endtask

    typedef struct {
        int         kind;
        int         addr;
        logic [4:0] exp;
        int         cycles;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int cur_kind, w0;
        vecs[0]  = '{0,   0, 5'b00000,  768};
        vecs[1]  = '{0, 255, 5'b00000,  768};
        vecs[2]  = '{1,  85, 5'b10000,  771};
        vecs[3]  = '{1,  84, 5'b00000,  771};
        vecs[4]  = '{2,  85, 5'b11111,  783};
        vecs[5]  = '{2,  84, 5'b10010,  783};
        vecs[6]  = '{2,  69, 5'b10001,  783};
        vecs[7]  = '{2,  86, 5'b11000,  783};
        vecs[8]  = '{2, 101, 5'b10100,  783};
        vecs[9]  = '{3,   0, 5'b10011, 1536};
        vecs[10] = '{3,  15, 5'b11001, 1536};
        vecs[11] = '{3, 255, 5'b11100, 1536};
        vecs[12] = '{3, 240, 5'b10110, 1536};
        vecs[13] = '{3, 100, 5'b11111, 1536};

        bus.start = 1'b0;
        bus.map_rd_data = 1'b0;
        load_map(0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", {bus.busy, bus.done, bus.map_rd_en, bus.mask_wr_en}, 0);
        check("rst_addrs", {bus.map_rd_addr, bus.mask_wr_addr}, 0);
        check("rst_wr_data", bus.mask_wr_data, 0);
        rst = 1'b0;
        @(negedge clk);

        cur_kind = -1;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].kind != cur_kind) begin
                cur_kind = vecs[i].kind;
                load_map(cur_kind);
                run_scan(0);
                check($sformatf("busy_cycles_kind%0d", cur_kind), busy_cycles, vecs[i].cycles);
            end
            check($sformatf("mask_vec%0d_addr%0d", i, vecs[i].addr), mask_ram[vecs[i].addr], vecs[i].exp);
        end

        // start re-pulsed mid-scan must not disturb the sequence
        load_map(3);
        run_scan(100);
        check("restart_ignored_cycles", busy_cycles, 1536);

        for (int k = 0; k < 3; k++) begin
            load_map(4);
            run_scan(0);
        end

        // reset 50 cycles into a scan aborts it
        load_map(3);
        clear_capture();
        collect = 1;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort_outputs", {bus.busy, bus.mask_wr_en, bus.done}, 0);
        w0 = wr_addr_q.size();
        repeat (10) @(negedge clk);
        check("abort_no_writes", wr_addr_q.size(), w0);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", bus.busy, 0);
        collect = 0;
        run_scan(0);

        // start coincident with reset is dropped
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("start_with_rst", {bus.busy, bus.map_rd_en}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
